// File: rtl/mini_mips_pkg.sv
// mini_mips_pkg: shared MDU op codes, FSM states and default datapath width.
package mini_mips_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_MADD  = 3'b010,
        MDU_MADDU = 3'b011,
        MDU_MUL   = 3'b100,
        MDU_MTHI  = 3'b101,
        MDU_MTLO  = 3'b110,
        MDU_RSVD  = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } mdu_state_t;

    function automatic logic mdu_is_mult(input mdu_op_t op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MUL};
    endfunction

    function automatic logic mdu_is_signed(input mdu_op_t op);
        return op inside {MDU_MULT, MDU_MADD, MDU_MUL};
    endfunction

    function automatic logic mdu_is_acc(input mdu_op_t op);
        return op inside {MDU_MADD, MDU_MADDU};
    endfunction

    // ALU-side alu_control encodings that route to the MDU
    function automatic mdu_op_t alu_to_mdu(input logic [3:0] ctl);
        return ctl == 4'b1011 ? MDU_MUL :
               ctl == 4'b1100 ? MDU_MADD :
               ctl == 4'b1101 ? MDU_MADDU : MDU_RSVD;
    endfunction

endpackage

// File: rtl/mdu_shift_add.sv
// mdu_shift_add: radix-2 shift-add magnitude multiplier, one multiplier bit per step.
module mdu_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               last_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        mcand_d  = load_i ? {{WIDTH{1'b0}}, a_i} : step_i ? mcand_q << 1 : mcand_q;
        mplier_d = load_i ? b_i : step_i ? mplier_q >> 1 : mplier_q;
        prod_d   = load_i ? '0 : (step_i && mplier_q[0]) ? prod_q + mcand_q : prod_q;
        cnt_d    = load_i ? CW'(WIDTH) : step_i ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    // high during the cycle whose step consumes the final multiplier bit
    assign last_o = cnt_q == CW'(1);
    assign prod_o = prod_q;

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/accumulate unit holding architectural HI/LO.
module mdu_hilo
    import mini_mips_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_q, state_d;
    mdu_op_t            op_e, op_q;
    logic               sign_q, accept, load, step, last, commit;
    logic [WIDTH-1:0]   hi_q, lo_q, result_q, a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, fixed, hilo_sum;

    assign op_e   = mdu_op_t'(op);
    assign accept = start && state_q == S_IDLE;
    assign a_mag  = (mdu_is_signed(op_e) && input1[WIDTH-1]) ? -input1 : input1;
    assign b_mag  = (mdu_is_signed(op_e) && input2[WIDTH-1]) ? -input2 : input2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = mdu_is_mult(op_e) ? S_CALC : S_DONE;
            S_CALC:  state_d = flush ? S_IDLE : last ? S_FIX : S_CALC;
            S_FIX:   state_d = flush ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = state_q == S_CALC || state_q == S_FIX;
        done   = state_q == S_DONE;
        load   = accept && mdu_is_mult(op_e);
        step   = state_q == S_CALC;
        commit = state_q == S_FIX && !flush;
    end

    mdu_shift_add #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .prod_o (prod),
        .last_o (last)
    );

    // two's-complement fix-up, then modulo-2^(2W) accumulate into HI/LO
    assign fixed    = sign_q ? -prod : prod;
    assign hilo_sum = fixed + (mdu_is_acc(op_q) ? {hi_q, lo_q} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MDU_MULT;
            sign_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_e;
                sign_q <= mdu_is_signed(op_e) && (input1[WIDTH-1] ^ input2[WIDTH-1]);
            end
            if (accept && op_e == MDU_MTHI) hi_q <= input1;
            if (accept && op_e == MDU_MTLO) lo_q <= input1;
            if (commit && op_q == MDU_MUL) result_q <= fixed[WIDTH-1:0];
            if (commit && op_q != MDU_MUL) {hi_q, lo_q} <= hilo_sum;
        end
    end

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign result = result_q;

endmodule
